pd_axil_regbank: RTL

PD_AXIL_REGBANK -- requirements
Module: pd_axil_regbank

---
 rtl/pd_axil_pkg.sv | 18 +
 rtl/pd_axil_byte_merge.sv | 26 ++
 rtl/pd_axil_regbank.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pd_axil_pkg.sv
// Shared definitions for the pd_axil register bank.
// Provides AXI response codes and a constant-evaluable ceil(log2) helper.
package pd_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pd_axil_byte_merge.sv
// Byte-lane merge: each byte of merged comes from new_data when its strobe is set,
// otherwise from old_data.
// Ports:
//   old_data  in  DW    current register value
//   new_data  in  DW    write data
//   strb      in  DW/8  byte strobes
//   merged    out DW    merged value (combinational)
module pd_axil_byte_merge #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]   old_data,
  input  logic [DW-1:0]   new_data,
  input  logic [DW/8-1:0] strb,
  output logic [DW-1:0]   merged
);

  localparam int unsigned SW = DW / 8;

  always_comb begin
    merged = old_data;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/pd_axil_regbank.sv
// AXI4-Lite slave register bank with per-register read-only masking.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   clock, async active-low reset
//   s00_axi_aw* / w* / b*            write address, data and response channels
//   s00_axi_ar* / r*                 read address and data channels
//   reg_out    out  NUM_REGS*DW      register contents (RO slots mirror status_in)
//   status_in  in   NUM_REGS*DW      values for read-only registers
//   wr_pulse   out  NUM_REGS         one-cycle strobe per accepted register write
module pd_axil_regbank
  import pd_axil_pkg::*;
#(
  parameter int unsigned          C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS           = 8,
  parameter int unsigned          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [NUM_REGS-1:0]  RO_MASK            = '0
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned LSB   = clog2(SW);
  localparam int unsigned IDX_W = clog2(NUM_REGS);
  localparam int unsigned UPW   = AW - LSB;

  // Elaboration-time parameter legality
  if (!(DW == 32 || DW == 64)) begin : g_bad_dw
    $error("C_S_AXI_DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 2 || NUM_REGS > 64) begin : g_bad_nr
    $error("NUM_REGS must be in 2..64");
  end
  if (AW < IDX_W + LSB) begin : g_bad_aw
    $error("C_S_AXI_ADDR_WIDTH too small for NUM_REGS");
  end

  logic [DW-1:0]  regs [NUM_REGS];

  // Latched write beats
  logic           aw_pend;
  logic [UPW-1:0] aw_up_q;
  logic           w_pend;
  logic [DW-1:0]  w_data_q;
  logic [SW-1:0]  w_strb_q;

  logic           aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
  logic           aw_have_c, w_have_c, do_write_c;
  logic [UPW-1:0] wr_up_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [DW-1:0]  wr_data_c, wr_old_c, wr_merged_c;
  logic [SW-1:0]  wr_strb_c;
  logic           wr_in_range_c, wr_ro_c, wr_ok_c;
  logic [UPW-1:0] rd_up_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic           rd_in_range_c;
  logic [DW-1:0]  rd_val_c;
  logic           bvalid_d_c, rvalid_d_c, aw_pend_d_c, w_pend_d_c;

  assign aw_hs_c = s00_axi_awvalid & s00_axi_awready;
  assign w_hs_c  = s00_axi_wvalid  & s00_axi_wready;
  assign b_hs_c  = s00_axi_bvalid  & s00_axi_bready;
  assign ar_hs_c = s00_axi_arvalid & s00_axi_arready;
  assign r_hs_c  = s00_axi_rvalid  & s00_axi_rready;

  // A beat is available if latched earlier or handshaking now
  assign aw_have_c  = aw_pend | aw_hs_c;
  assign w_have_c   = w_pend  | w_hs_c;
  assign do_write_c = aw_have_c & w_have_c;

  assign wr_up_c   = aw_pend ? aw_up_q  : s00_axi_awaddr[AW-1:LSB];
  assign wr_data_c = w_pend  ? w_data_q : s00_axi_wdata;
  assign wr_strb_c = w_pend  ? w_strb_q : s00_axi_wstrb;
  assign wr_idx_c  = wr_up_c[IDX_W-1:0];
  assign wr_in_range_c = {1'b0, wr_up_c} < (UPW+1)'(NUM_REGS);
  assign wr_ok_c   = do_write_c & wr_in_range_c & ~wr_ro_c;

  assign rd_up_c   = s00_axi_araddr[AW-1:LSB];
  assign rd_idx_c  = rd_up_c[IDX_W-1:0];
  assign rd_in_range_c = {1'b0, rd_up_c} < (UPW+1)'(NUM_REGS);

  assign aw_pend_d_c = aw_have_c & ~do_write_c;
  assign w_pend_d_c  = w_have_c  & ~do_write_c;
  assign bvalid_d_c  = do_write_c | (s00_axi_bvalid & ~b_hs_c);
  assign rvalid_d_c  = ar_hs_c    | (s00_axi_rvalid & ~r_hs_c);

  // Register select muxes for the write merge and the read path
  always_comb begin
    wr_old_c = '0;
    wr_ro_c  = 1'b0;
    rd_val_c = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_idx_c == IDX_W'(k)) begin
        wr_old_c = regs[k];
        wr_ro_c  = RO_MASK[k];
      end
      if (rd_idx_c == IDX_W'(k)) begin
        rd_val_c = RO_MASK[k] ? status_in[k*DW +: DW] : regs[k];
      end
    end
  end

  pd_axil_byte_merge #(.DW(DW)) u_merge (
    .old_data (wr_old_c),
    .new_data (wr_data_c),
    .strb     (wr_strb_c),
    .merged   (wr_merged_c)
  );

  // Write channels, register storage and write strobes
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      aw_pend         <= 1'b0;
      aw_up_q         <= '0;
      w_pend          <= 1'b0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
      wr_pulse        <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_ok_c) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_idx_c == IDX_W'(k) && !RO_MASK[k]) begin
            regs[k]     <= wr_merged_c;
            wr_pulse[k] <= 1'b1;
          end
        end
      end
      if (aw_hs_c) aw_up_q <= s00_axi_awaddr[AW-1:LSB];
      if (w_hs_c) begin
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end
      aw_pend         <= aw_pend_d_c;
      w_pend          <= w_pend_d_c;
      s00_axi_bvalid  <= bvalid_d_c;
      if (do_write_c) s00_axi_bresp <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
      s00_axi_awready <= ~aw_pend_d_c & ~bvalid_d_c;
      s00_axi_wready  <= ~w_pend_d_c  & ~bvalid_d_c;
    end
  end

  // Read channels; rdata is captured at the AR handshake
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
    end else begin
      if (ar_hs_c) begin
        s00_axi_rdata <= rd_in_range_c ? rd_val_c : '0;
        s00_axi_rresp <= rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
      end
      s00_axi_rvalid  <= rvalid_d_c;
      s00_axi_arready <= ~rvalid_d_c;
    end
  end

  // Read-only slots pass status_in straight through
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    if (RO_MASK[k]) begin : g_ro
      assign reg_out[k*DW +: DW] = status_in[k*DW +: DW];
    end else begin : g_rw
      assign reg_out[k*DW +: DW] = regs[k];
    end
  end

  logic unused;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[LSB-1:0],
                    s00_axi_araddr[LSB-1:0], status_in};

endmodule
